// File: rtl/vga_fifo_line_reader_if.sv
`timescale 1ns/1ps
// Pixel FIFO read port plus the line-load request channel toward the SDRAM-side loader.
interface vga_fifo_line_reader_if;
   logic [7:0]  iFIFO_RDATA;
   logic        iFIFO_EMPTY;
   logic        oFIFO_REN;
   logic [12:0] oVGA_LINE_TO_LOAD;
   logic        oVGA_LOAD_TO_FIFO_REQ;

   modport master (
      input  iFIFO_RDATA,
      input  iFIFO_EMPTY,
      output oFIFO_REN,
      output oVGA_LINE_TO_LOAD,
      output oVGA_LOAD_TO_FIFO_REQ
   );

   modport slave (
      output iFIFO_RDATA,
      output iFIFO_EMPTY,
      input  oFIFO_REN,
      input  oVGA_LINE_TO_LOAD,
      input  oVGA_LOAD_TO_FIFO_REQ
   );
endinterface

// File: rtl/vga_fifo_line_reader.sv
`timescale 1ns/1ps
// VGA raster generator draining a show-ahead per-line pixel FIFO; requests the next line in h-blank.
// Optional macro VGA_READER_VFLUSH_EN: discard leftover FIFO words during the first vertical-blank line.
module vga_fifo_line_reader #(
   parameter int         H_ACTIVE      = 1280,
   parameter int         H_FP          = 48,
   parameter int         H_SYNC        = 112,
   parameter int         H_BP          = 248,
   parameter int         V_ACTIVE      = 1024,
   parameter int         V_FP          = 1,
   parameter int         V_SYNC        = 3,
   parameter int         V_BP          = 38,
   parameter int         REQ_LEN       = 4,
   parameter logic       SYNC_POL      = 1'b1,
   parameter logic [7:0] UNDERFLOW_PIX = 8'h00
) (
   input  logic                          iCLK,
   input  logic                          iRST_N,
   vga_fifo_line_reader_if.master        fifoBus,
   output logic                          oHS,
   output logic                          oVS,
   output logic                          oBLANK_N,
   output logic [7:0]                    oPIXEL,
   input  logic                          iUNDERFLOW_CLR,
   output logic                          oUNDERFLOW
);

   localparam logic [12:0] H_LAST   = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
   localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] REQ_END  = 13'(H_ACTIVE + REQ_LEN);
   localparam logic [12:0] V_LAST   = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
   localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

   logic [12:0] hcnt_q, hcnt_d;
   logic [12:0] vcnt_q, vcnt_d;
   logic [12:0] line_q, line_d;
   logic [12:0] nxtLine;
   logic        req_q, req_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        blank_q, blank_d;
   logic [7:0]  pixel_q, pixel_d;
   logic        underflow_q, underflow_d;
   logic        active;
   logic        hsRegion;
   logic        vsRegion;
   logic        flushLine;
   logic        fifoEmpty;

   assign fifoEmpty = fifoBus.iFIFO_EMPTY;

`ifdef VGA_READER_VFLUSH_EN
   assign flushLine = (vcnt_q == V_ACT);
`else
   assign flushLine = 1'b0;
`endif

   // Raster position, derived regions and the next-state of every registered output.
   always_comb begin
      nxtLine     = (vcnt_q == V_LAST) ? 13'd0 : vcnt_q + 13'd1;
      active      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hsRegion    = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
      vsRegion    = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

      hcnt_d      = hcnt_q + 13'd1;
      vcnt_d      = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = 13'd0;
         vcnt_d = nxtLine;
      end

      // A window starting at H_ACTIVE, once registered, lands on H_ACTIVE+1..H_ACTIVE+REQ_LEN.
      req_d       = (hcnt_q >= H_ACT) && (hcnt_q < REQ_END) && (nxtLine < V_ACT);
      line_d      = line_q;
      if ((hcnt_q == H_ACT) && (nxtLine < V_ACT)) begin
         line_d = nxtLine;
      end

      hs_d        = hsRegion ? SYNC_POL : ~SYNC_POL;
      vs_d        = vsRegion ? SYNC_POL : ~SYNC_POL;
      blank_d     = active;

      pixel_d     = 8'h00;
      underflow_d = iUNDERFLOW_CLR ? 1'b0 : underflow_q;
      if (active) begin
         if (fifoEmpty) begin
            pixel_d     = UNDERFLOW_PIX;
            underflow_d = 1'b1;
         end else begin
            pixel_d     = fifoBus.iFIFO_RDATA;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         hcnt_q      <= 13'd0;
         vcnt_q      <= 13'd0;
         line_q      <= 13'd0;
         req_q       <= 1'b0;
         hs_q        <= ~SYNC_POL;
         vs_q        <= ~SYNC_POL;
         blank_q     <= 1'b0;
         pixel_q     <= 8'h00;
         underflow_q <= 1'b0;
      end else begin
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         line_q      <= line_d;
         req_q       <= req_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         blank_q     <= blank_d;
         pixel_q     <= pixel_d;
         underflow_q <= underflow_d;
      end
   end

   // The read strobe follows the live counters; the reset term keeps it quiet while the raster is held.
   assign fifoBus.oFIFO_REN             = iRST_N && !fifoEmpty && (active || flushLine);
   assign fifoBus.oVGA_LINE_TO_LOAD     = line_q;
   assign fifoBus.oVGA_LOAD_TO_FIFO_REQ = req_q;
   assign oHS                           = hs_q;
   assign oVS                           = vs_q;
   assign oBLANK_N                      = blank_q;
   assign oPIXEL                        = pixel_q;
   assign oUNDERFLOW                    = underflow_q;

endmodule

// File: tb/tb_vga_fifo_line_reader.sv
`timescale 1ns/1ps
// Directed bench for vga_fifo_line_reader on a shrunken 18x8 raster with a queue-based FIFO and loader model.
module tb_vga_fifo_line_reader;

   localparam logic [7:0] UF_PIX = 8'hEE;
`ifdef VGA_READER_VFLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic        iCLK = 1'b0;
   logic        iRST_N;
   logic        oHS;
   logic        oVS;
   logic        oBLANK_N;
   logic [7:0]  oPIXEL;
   logic        iUNDERFLOW_CLR;
   logic        oUNDERFLOW;

   int          checkCount = 0;
   int          errorCount = 0;
   int          cyc;
   int          skipLine;
   int          extraLine;
   logic        renAtEdge;
   logic        reqPrev;
   logic        rstSeen;
   logic [7:0]  fifoQ[$];

   vga_fifo_line_reader_if fifoBus ();

   vga_fifo_line_reader #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(5),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .REQ_LEN(4), .SYNC_POL(1'b1), .UNDERFLOW_PIX(UF_PIX)
   ) dut (
      .iCLK           (iCLK),
      .iRST_N         (iRST_N),
      .fifoBus        (fifoBus.master),
      .oHS            (oHS),
      .oVS            (oVS),
      .oBLANK_N       (oBLANK_N),
      .oPIXEL         (oPIXEL),
      .iUNDERFLOW_CLR (iUNDERFLOW_CLR),
      .oUNDERFLOW     (oUNDERFLOW)
   );

   always #5 iCLK = ~iCLK;

   // Raster position as the bench sees it: number of active edges since reset release.
   always @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   always @(posedge iCLK) renAtEdge <= fifoBus.oFIFO_REN;

   // FIFO and loader model: pop what the DUT acknowledged, answer each REQ rise with one line of words.
   always @(negedge iCLK) begin
      if (!iRST_N) begin
         fifoQ.delete();
         fifoQ.push_back(8'h77);
         reqPrev = 1'b0;
         rstSeen = 1'b1;
      end else begin
         if (rstSeen) begin
            fifoQ.delete();
            rstSeen = 1'b0;
         end else if (renAtEdge && fifoQ.size() > 0) begin
            void'(fifoQ.pop_front());
         end
         if (fifoBus.oVGA_LOAD_TO_FIFO_REQ && !reqPrev &&
             int'(fifoBus.oVGA_LINE_TO_LOAD) != skipLine) begin
            for (int x = 0; x < ((int'(fifoBus.oVGA_LINE_TO_LOAD) == extraLine) ? 10 : 8); x++)
               fifoQ.push_back(8'(int'(fifoBus.oVGA_LINE_TO_LOAD) * 16 + x + 1));
         end
         reqPrev = fifoBus.oVGA_LOAD_TO_FIFO_REQ;
      end
      fifoBus.iFIFO_EMPTY = (fifoQ.size() == 0);
      fifoBus.iFIFO_RDATA = (fifoQ.size() == 0) ? 8'h00 : fifoQ[0];
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to raster position k and settle just after the falling edge.
   task automatic applyStimulus(input int k);
      int guard = 0;
      while (cyc < k && guard < 5000) begin
         @(negedge iCLK);
         guard++;
      end
      #1;
      if (cyc != k) checkOutput("position reached", 32'(cyc), 32'(k));
   endtask

   task automatic releaseReset();
      @(posedge iCLK);
      #2 iRST_N = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      iRST_N         = 1'b0;
      iUNDERFLOW_CLR = 1'b0;
      skipLine       = 2;
      extraLine      = -1;
      $display("[TB] reset with a word waiting in the FIFO");
      repeat (3) @(negedge iCLK);
      #1;
      checkOutput("rst oHS", 32'(oHS), 32'd0);
      checkOutput("rst oVS", 32'(oVS), 32'd0);
      checkOutput("rst oBLANK_N", 32'(oBLANK_N), 32'd0);
      checkOutput("rst oPIXEL", 32'(oPIXEL), 32'd0);
      checkOutput("rst REQ", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd0);
      checkOutput("rst LINE", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd0);
      checkOutput("rst oUNDERFLOW", 32'(oUNDERFLOW), 32'd0);
      checkOutput("rst REN gated", 32'(fifoBus.oFIFO_REN), 32'd0);
      releaseReset();

      $display("[TB] frame 1: line 0 unloaded, line 2 withheld");
      applyStimulus(1);
      checkOutput("f1 l0 blank", 32'(oBLANK_N), 32'd1);
      checkOutput("f1 l0 underflow pix", 32'(oPIXEL), 32'(UF_PIX));
      checkOutput("f1 l0 underflow flag", 32'(oUNDERFLOW), 32'd1);
      checkOutput("f1 l0 no REN when empty", 32'(fifoBus.oFIFO_REN), 32'd0);
      applyStimulus(8);
      checkOutput("REQ before window", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd0);
      applyStimulus(9);
      checkOutput("REQ rise", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd1);
      checkOutput("LINE 1", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd1);
      applyStimulus(10);
      checkOutput("oHS before sync", 32'(oHS), 32'd0);
      applyStimulus(11);
      checkOutput("oHS first active", 32'(oHS), 32'd1);
      applyStimulus(12);
      checkOutput("REQ last clock", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd1);
      applyStimulus(13);
      checkOutput("REQ fall", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd0);
      checkOutput("oHS last active", 32'(oHS), 32'd1);
      applyStimulus(14);
      checkOutput("oHS end", 32'(oHS), 32'd0);
      applyStimulus(18);
      checkOutput("l1 REN", 32'(fifoBus.oFIFO_REN), 32'd1);
      applyStimulus(19);
      checkOutput("l1 pix0", 32'(oPIXEL), 32'h11);
      applyStimulus(26);
      checkOutput("l1 pix7", 32'(oPIXEL), 32'h18);
      checkOutput("l1 blank last", 32'(oBLANK_N), 32'd1);
      applyStimulus(27);
      checkOutput("l1 hblank pix", 32'(oPIXEL), 32'd0);
      checkOutput("l1 hblank blank", 32'(oBLANK_N), 32'd0);
      checkOutput("flag sticky", 32'(oUNDERFLOW), 32'd1);
      checkOutput("LINE 2", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd2);
      iUNDERFLOW_CLR = 1'b1;
      applyStimulus(28);
      iUNDERFLOW_CLR = 1'b0;
      checkOutput("flag cleared", 32'(oUNDERFLOW), 32'd0);
      applyStimulus(29);
      checkOutput("oHS period", 32'(oHS), 32'd1);
      applyStimulus(37);
      checkOutput("l2 underflow pix", 32'(oPIXEL), 32'(UF_PIX));
      checkOutput("l2 underflow flag", 32'(oUNDERFLOW), 32'd1);
      applyStimulus(40);
      iUNDERFLOW_CLR = 1'b1;
      applyStimulus(41);
      iUNDERFLOW_CLR = 1'b0;
      checkOutput("underflow beats clear", 32'(oUNDERFLOW), 32'd1);
      applyStimulus(44);
      checkOutput("l2 pix7 underflow", 32'(oPIXEL), 32'(UF_PIX));
      applyStimulus(45);
      checkOutput("l2 flag held", 32'(oUNDERFLOW), 32'd1);
      checkOutput("LINE 3", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd3);
      iUNDERFLOW_CLR = 1'b1;
      applyStimulus(46);
      iUNDERFLOW_CLR = 1'b0;
      checkOutput("l2 flag cleared", 32'(oUNDERFLOW), 32'd0);
      applyStimulus(55);
      checkOutput("l3 pix0", 32'(oPIXEL), 32'h31);
      applyStimulus(62);
      checkOutput("l3 pix7", 32'(oPIXEL), 32'h38);
      applyStimulus(63);
      checkOutput("no REQ for blank line", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd0);
      checkOutput("LINE holds", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd3);
      applyStimulus(90);
      checkOutput("oVS before sync", 32'(oVS), 32'd0);
      applyStimulus(91);
      checkOutput("oVS active", 32'(oVS), 32'd1);
      applyStimulus(99);
      checkOutput("no REQ in vsync", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd0);
      skipLine = -1;
      applyStimulus(126);
      checkOutput("oVS last", 32'(oVS), 32'd1);
      applyStimulus(127);
      checkOutput("oVS end", 32'(oVS), 32'd0);
      applyStimulus(135);
      checkOutput("line 0 REQ", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd1);
      checkOutput("LINE 0", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd0);
      applyStimulus(140);
      extraLine = 1;

      $display("[TB] frame 2: line 1 gets two extra words");
      applyStimulus(145);
      checkOutput("f2 l0 pix0", 32'(oPIXEL), 32'h01);
      checkOutput("f2 l0 no underflow", 32'(oUNDERFLOW), 32'd0);
      applyStimulus(160);
      extraLine = -1;
      applyStimulus(163);
      checkOutput("f2 l1 pix0", 32'(oPIXEL), 32'h11);
      applyStimulus(170);
      checkOutput("f2 l1 pix7", 32'(oPIXEL), 32'h18);
      applyStimulus(181);
      checkOutput("f2 l2 residue0", 32'(oPIXEL), 32'h19);
      applyStimulus(182);
      checkOutput("f2 l2 residue1", 32'(oPIXEL), 32'h1A);
      applyStimulus(183);
      checkOutput("f2 l2 shifted", 32'(oPIXEL), 32'h21);
      applyStimulus(188);
      checkOutput("f2 l2 pix7", 32'(oPIXEL), 32'h26);
      applyStimulus(199);
      checkOutput("f2 l3 pix0", 32'(oPIXEL), 32'h27);
      applyStimulus(201);
      checkOutput("f2 l3 pix2", 32'(oPIXEL), 32'h31);
      applyStimulus(216);
      checkOutput("vblank first line REN", 32'(fifoBus.oFIFO_REN), 32'(FLUSH));
      applyStimulus(217);
      checkOutput("vblank pix", 32'(oPIXEL), 32'd0);
      checkOutput("vblank blank", 32'(oBLANK_N), 32'd0);
      applyStimulus(234);
      checkOutput("FIFO empty after vblank line", 32'(fifoBus.iFIFO_EMPTY), 32'(FLUSH));
      applyStimulus(235);
      checkOutput("no underflow in vblank", 32'(oUNDERFLOW), 32'd0);
      applyStimulus(289);
      checkOutput("f3 l0 pix0", 32'(oPIXEL), FLUSH ? 32'h01 : 32'h37);
      applyStimulus(291);
      checkOutput("f3 l0 pix2", 32'(oPIXEL), FLUSH ? 32'h03 : 32'h01);

      $display("[TB] reset during a load request");
      applyStimulus(299);
      checkOutput("pre-reset REQ", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd1);
      checkOutput("pre-reset LINE", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd1);
      checkOutput("pre-reset oHS", 32'(oHS), 32'd1);
      iRST_N = 1'b0;
      #1;
      checkOutput("mid rst REQ", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd0);
      checkOutput("mid rst LINE", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd0);
      checkOutput("mid rst oHS", 32'(oHS), 32'd0);
      checkOutput("mid rst oPIXEL", 32'(oPIXEL), 32'd0);
      @(negedge iCLK);
      #1;
      checkOutput("mid rst REN gated", 32'(fifoBus.oFIFO_REN), 32'd0);
      releaseReset();
      applyStimulus(1);
      checkOutput("restart blank", 32'(oBLANK_N), 32'd1);
      checkOutput("restart underflow pix", 32'(oPIXEL), 32'(UF_PIX));
      checkOutput("restart flag", 32'(oUNDERFLOW), 32'd1);
      applyStimulus(9);
      checkOutput("restart REQ", 32'(fifoBus.oVGA_LOAD_TO_FIFO_REQ), 32'd1);
      checkOutput("restart LINE", 32'(fifoBus.oVGA_LINE_TO_LOAD), 32'd1);
      applyStimulus(11);
      checkOutput("restart oHS", 32'(oHS), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/vga_fifo_line_reader.md
# vga_fifo_line_reader

Display-side consumer of the per-line pixel FIFO. It generates VGA raster timing and asks the SDRAM-side loader for the next line during horizontal blanking via a line number plus a load-request pulse. During active video it drains the show-ahead FIFO at one 8-bit pixel per clock and drives registered sync, blank and pixel outputs. It also detects and flags FIFO underflow.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch
- V_ACTIVE, 1024, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch
- REQ_LEN, 4, load-request pulse width in clocks (≥2)
- SYNC_POL, 1, active level of oHS/oVS
- UNDERFLOW_PIX, 8'h00, pixel value substituted on underflow

Ports:
- iCLK  in  1  pixel clock; the loader shares this clock
- iRST_N  in  1  reset, asynchronous, active-low
- iFIFO_RDATA  in  8  show-ahead FIFO head word, valid whenever !iFIFO_EMPTY
- iFIFO_EMPTY  in  1  FIFO empty
- oFIFO_REN  out  1  read acknowledge; pops the head word this clock
- oVGA_LINE_TO_LOAD  out  13  line number the loader must fetch
- oVGA_LOAD_TO_FIFO_REQ  out  1  load-request pulse
- oHS, oVS  out  1  syncs
- oBLANK_N  out  1  high during active video
- oPIXEL  out  8  pixel value
- iUNDERFLOW_CLR  in  1  clears oUNDERFLOW
- oUNDERFLOW  out  1  sticky underflow flag

## Operation
- Counters: hcnt runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP. vcnt runs 0..V_TOTAL-1 and increments when hcnt wraps. Both wrap to 0 at the top of their range.
- active = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE).
- HS region: hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS region is defined the same way on vcnt.
- nxt = (vcnt==V_TOTAL-1) ? 0 : vcnt+1.
- Load request: when hcnt==H_ACTIVE and nxt<V_ACTIVE, latch oVGA_LINE_TO_LOAD=nxt and assert REQ for REQ_LEN clocks. Line 0 is therefore requested on the last line of vertical blanking. No request is issued for blanking lines.
- oVGA_LINE_TO_LOAD holds its value until the next request.
- Read: oFIFO_REN = active && !iFIFO_EMPTY (combinational).
- Pixel: if active and !empty, oPIXEL <= iFIFO_RDATA. If active and empty, oPIXEL <= UNDERFLOW_PIX and oUNDERFLOW <= 1. If not active, oPIXEL <= 0.
- oUNDERFLOW clears on iUNDERFLOW_CLR. A new underflow in the same clock wins over the clear.
- FIFO depth requirement: ≥512 words. The loader writes one word per clock starting about H_TOTAL-H_ACTIVE-REQ_LEN clocks before reads begin.

## Timing
- Output latency: oHS, oVS, oBLANK_N and oPIXEL are registered one clock after the counter state that defines them, so all four stay mutually aligned. oFIFO_REN is aligned with the counter state (it is not registered).
- REQ timing: high on the clocks where hcnt is in [H_ACTIVE+1, H_ACTIVE+REQ_LEN]. oVGA_LINE_TO_LOAD changes on the same edge REQ rises.
- Reset values: hcnt=vcnt=0, oHS=oVS=!SYNC_POL, oBLANK_N=0, oPIXEL=0, REQ=0, oVGA_LINE_TO_LOAD=0, oUNDERFLOW=0. oFIFO_REN is 0 while reset is asserted.
- Reset mid-line: the raster restarts at (0,0) and any in-progress REQ pulse is truncated. The first post-reset frame has no line 0 loaded and underflows; this is expected.
- Empty deasserting mid-line: reading resumes on that clock. Skipped pixels are not recovered, so the line is shifted.

## Configuration
- VGA_READER_VFLUSH_EN defined: on vcnt==V_ACTIVE (the first vertical-blank line), oFIFO_REN = !iFIFO_EMPTY for the whole line. This discards residual words so every frame starts aligned. oPIXEL stays 0 and no underflow is flagged.
- VGA_READER_VFLUSH_EN undefined: no reads occur outside active video, and residue carries into the next frame.

## Test plan
- Reset release, FIFO empty: oHS first reaches SYNC_POL at clock H_ACTIVE+H_FP+1. The HS period is 1688 clocks and the VS period is 1066 lines.
- Model loader answers every REQ with 1280 writes: REQ pulses 4 clocks at hcnt 1281..1284 with oVGA_LINE_TO_LOAD=vcnt+1. On vcnt=1065, line 0 is requested. The 1280 pixels appear in order with zero underflow.
- Loader withholds line 5: oPIXEL=UNDERFLOW_PIX across line 5 and oUNDERFLOW=1. The flag remains set until iUNDERFLOW_CLR, then clears.
- iUNDERFLOW_CLR asserted in the same clock as an underflow: oUNDERFLOW stays 1.
- Loader writes 1290 words for line 10, with VGA_READER_VFLUSH_EN defined: line 11 and later lines shift by 10. After the flush line, frame 2 line 0 is correct and the FIFO is empty at vcnt=1025. Without the macro, the shift persists into frame 2.
- iRST_N pulsed low at hcnt=1282 (REQ high): REQ drops immediately and all outputs return to their reset values. Timing restarts from (0,0).
